// File: rtl/dram_req_arbiter.sv
//==============================================================================
// Module  : dram_req_arbiter
// Purpose : Two-client arbiter for the DRAM request/write-data FIFOs with in-order
//           read-data return. Optional macro DRAM_ARB_PRIO_EN selects fixed priority.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dram_req_arbiter #(
    parameter int LOG_DRAM_SIZE = 6,
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
    parameter int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE,
    parameter int TAG_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     c0_req_valid,
    input  logic                     c0_req_we,
    input  logic [LOG_ADDR_SIZE-1:0] c0_req_addr,
    input  logic [PAGE_LEN-1:0]      c0_wdata,
    output logic                     c0_req_ready,
    output logic                     c0_rd_valid,
    output logic [PAGE_LEN-1:0]      c0_rd_data,
    input  logic                     c1_req_valid,
    input  logic                     c1_req_we,
    input  logic [LOG_ADDR_SIZE-1:0] c1_req_addr,
    input  logic [PAGE_LEN-1:0]      c1_wdata,
    output logic                     c1_req_ready,
    output logic                     c1_rd_valid,
    output logic [PAGE_LEN-1:0]      c1_rd_data,
    output logic                     frq_write_en,
    output logic [LOG_REQ_SIZE-1:0]  frq_write_data,
    input  logic                     frq_full,
    output logic                     fin_write_en,
    output logic [PAGE_LEN-1:0]      fin_write_data,
    input  logic                     fin_full,
    output logic                     fout_read_en,
    input  logic [PAGE_LEN-1:0]      fout_read_data,
    input  logic                     fout_empty,
    output logic                     error
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_TAG_FULL = CNT_W'(TAG_DEPTH);

    typedef enum logic [0:0] {IDLE  = 1'b0, ISSUE = 1'b1} issue_state_t;
    typedef enum logic [0:0] {RIDLE = 1'b0, RPOP  = 1'b1} ret_state_t;

    issue_state_t              issue_state_q, issue_state_d;
    ret_state_t                ret_state_q,   ret_state_d;
    logic                      last_grant_q,  last_grant_d;
    logic                      gnt_client_q,  gnt_client_d;
    logic                      frq_we_q,      frq_we_d;
    logic [LOG_REQ_SIZE-1:0]   frq_data_q,    frq_data_d;
    logic                      fin_we_q,      fin_we_d;
    logic [PAGE_LEN-1:0]       fin_data_q,    fin_data_d;
    logic                      fout_re_q,     fout_re_d;
    logic                      c0_rdv_q,      c0_rdv_d;
    logic                      c1_rdv_q,      c1_rdv_d;
    logic [PAGE_LEN-1:0]       c0_rdd_q,      c0_rdd_d;
    logic [PAGE_LEN-1:0]       c1_rdd_q,      c1_rdd_d;
    logic                      error_q,       error_d;
    logic [TAG_DEPTH-1:0]      tag_mem_q,     tag_mem_d;
    logic [PTR_W-1:0]          tag_wr_q,      tag_wr_d;
    logic [PTR_W-1:0]          tag_rd_q,      tag_rd_d;
    logic [CNT_W-1:0]          tag_cnt_q,     tag_cnt_d;

    logic w_tags_avail;
    logic w_c0_elig;
    logic w_c1_elig;
    logic w_sel;
    logic w_tag_push;
    logic w_tag_pop;

    assign w_tags_avail = (tag_cnt_q != C_TAG_FULL);
    assign w_c0_elig    = c0_req_valid && !frq_full && (c0_req_we ? !fin_full : w_tags_avail);
    assign w_c1_elig    = c1_req_valid && !frq_full && (c1_req_we ? !fin_full : w_tags_avail);
    // The ISSUE cycle still holds the granted request word, so bit 0 tells read from write.
    assign w_tag_push   = (issue_state_q == ISSUE) && !frq_data_q[0];

    always_comb begin
        w_sel = 1'b0;
        if (w_c0_elig && w_c1_elig) begin
`ifdef DRAM_ARB_PRIO_EN
            w_sel = 1'b0;
`else
            w_sel = ~last_grant_q;
`endif
        end else if (w_c1_elig) begin
            w_sel = 1'b1;
        end
    end

    // Issue FSM
    always_comb begin
        issue_state_d = issue_state_q;
        last_grant_d  = last_grant_q;
        gnt_client_d  = gnt_client_q;
        frq_we_d      = 1'b0;
        frq_data_d    = frq_data_q;
        fin_we_d      = 1'b0;
        fin_data_d    = fin_data_q;
        c0_req_ready  = 1'b0;
        c1_req_ready  = 1'b0;
        case (issue_state_q)
            IDLE: begin
                if (w_c0_elig || w_c1_elig) begin
                    c0_req_ready  = !w_sel;
                    c1_req_ready  = w_sel;
                    last_grant_d  = w_sel;
                    gnt_client_d  = w_sel;
                    frq_we_d      = 1'b1;
                    frq_data_d    = w_sel ? {c1_req_addr, c1_req_we} : {c0_req_addr, c0_req_we};
                    fin_we_d      = w_sel ? c1_req_we : c0_req_we;
                    if (w_sel ? c1_req_we : c0_req_we) begin
                        fin_data_d = w_sel ? c1_wdata : c0_wdata;
                    end
                    issue_state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_state_d = IDLE;
            end
            default: begin
                issue_state_d = IDLE;
            end
        endcase
    end

    // Return FSM
    always_comb begin
        ret_state_d = ret_state_q;
        fout_re_d   = 1'b0;
        c0_rdv_d    = 1'b0;
        c1_rdv_d    = 1'b0;
        c0_rdd_d    = c0_rdd_q;
        c1_rdd_d    = c1_rdd_q;
        error_d     = error_q;
        w_tag_pop   = 1'b0;
        case (ret_state_q)
            RIDLE: begin
                if (!fout_empty) begin
                    if (tag_cnt_q != '0) begin
                        fout_re_d   = 1'b1;
                        w_tag_pop   = 1'b1;
                        ret_state_d = RPOP;
                        if (tag_mem_q[tag_rd_q]) begin
                            c1_rdv_d = 1'b1;
                            c1_rdd_d = fout_read_data;
                        end else begin
                            c0_rdv_d = 1'b1;
                            c0_rdd_d = fout_read_data;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RPOP: begin
                ret_state_d = RIDLE;
            end
            default: begin
                ret_state_d = RIDLE;
            end
        endcase
    end

    // In-order tag queue; pointers wrap naturally since TAG_DEPTH is a power of two.
    always_comb begin
        tag_mem_d = tag_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        if (w_tag_push) begin
            tag_mem_d[tag_wr_q] = gnt_client_q;
            tag_wr_d            = tag_wr_q + PTR_W'(1);
        end
        if (w_tag_pop) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end
        if (w_tag_push && !w_tag_pop) begin
            tag_cnt_d = tag_cnt_q + CNT_W'(1);
        end else if (!w_tag_push && w_tag_pop) begin
            tag_cnt_d = tag_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_state_q <= IDLE;
            ret_state_q   <= RIDLE;
            last_grant_q  <= 1'b1;
            gnt_client_q  <= 1'b0;
            frq_we_q      <= 1'b0;
            frq_data_q    <= '0;
            fin_we_q      <= 1'b0;
            fin_data_q    <= '0;
            fout_re_q     <= 1'b0;
            c0_rdv_q      <= 1'b0;
            c1_rdv_q      <= 1'b0;
            c0_rdd_q      <= '0;
            c1_rdd_q      <= '0;
            error_q       <= 1'b0;
            tag_mem_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_cnt_q     <= '0;
        end else begin
            issue_state_q <= issue_state_d;
            ret_state_q   <= ret_state_d;
            last_grant_q  <= last_grant_d;
            gnt_client_q  <= gnt_client_d;
            frq_we_q      <= frq_we_d;
            frq_data_q    <= frq_data_d;
            fin_we_q      <= fin_we_d;
            fin_data_q    <= fin_data_d;
            fout_re_q     <= fout_re_d;
            c0_rdv_q      <= c0_rdv_d;
            c1_rdv_q      <= c1_rdv_d;
            c0_rdd_q      <= c0_rdd_d;
            c1_rdd_q      <= c1_rdd_d;
            error_q       <= error_d;
            tag_mem_q     <= tag_mem_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_cnt_q     <= tag_cnt_d;
        end
    end

    assign frq_write_en   = frq_we_q;
    assign frq_write_data = frq_data_q;
    assign fin_write_en   = fin_we_q;
    assign fin_write_data = fin_data_q;
    assign fout_read_en   = fout_re_q;
    assign c0_rd_valid    = c0_rdv_q;
    assign c1_rd_valid    = c1_rdv_q;
    assign c0_rd_data     = c0_rdd_q;
    assign c1_rd_data     = c1_rdd_q;
    assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_req_arbiter.sv
//==============================================================================
// Module  : tb_dram_req_arbiter
// Purpose : Directed self-checking bench for dram_req_arbiter.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_dram_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req_valid, c0_req_we, c1_req_valid, c1_req_we;
    logic [0:0]  c0_req_addr, c1_req_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_req_ready, c1_req_ready, c0_rd_valid, c1_rd_valid;
    logic [31:0] c0_rd_data, c1_rd_data;
    logic        frq_write_en, frq_full, fin_write_en, fin_full;
    logic [1:0]  frq_write_data;
    logic [31:0] fin_write_data, fout_read_data;
    logic        fout_read_en, fout_empty, error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dram_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req_valid(c0_req_valid), .c0_req_we(c0_req_we), .c0_req_addr(c0_req_addr),
        .c0_wdata(c0_wdata), .c0_req_ready(c0_req_ready), .c0_rd_valid(c0_rd_valid),
        .c0_rd_data(c0_rd_data),
        .c1_req_valid(c1_req_valid), .c1_req_we(c1_req_we), .c1_req_addr(c1_req_addr),
        .c1_wdata(c1_wdata), .c1_req_ready(c1_req_ready), .c1_rd_valid(c1_rd_valid),
        .c1_rd_data(c1_rd_data),
        .frq_write_en(frq_write_en), .frq_write_data(frq_write_data), .frq_full(frq_full),
        .fin_write_en(fin_write_en), .fin_write_data(fin_write_data), .fin_full(fin_full),
        .fout_read_en(fout_read_en), .fout_read_data(fout_read_data), .fout_empty(fout_empty),
        .error(error)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after a rising edge with reset released; checks the reset state.
    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        c0_req_valid = 0; c0_req_we = 0; c0_req_addr = 0; c0_wdata = 0;
        c1_req_valid = 0; c1_req_we = 0; c1_req_addr = 0; c1_wdata = 0;
        frq_full = 0; fin_full = 0; fout_empty = 1; fout_read_data = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({frq_write_en, fin_write_en, fout_read_en, c0_rd_valid, c1_rd_valid, error,
             frq_write_data, fin_write_data, c0_rd_data, c1_rd_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got nonzero (frq_en=%b fin_en=%b fout_re=%b err=%b) want all 0",
                     frq_write_en, fin_write_en, fout_read_en, error);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        test_reset();
        c0_req_valid = 1; c0_req_we = 1; c0_req_addr = 1; c0_wdata = 32'h1;
        @(negedge clk);
        n_cmp++;
        if ({c0_req_ready, c1_req_ready} !== 2'b10) begin
            n_bad++; $display("FAIL wr_ready: got %b want 10", {c0_req_ready, c1_req_ready});
        end
        next_cycle();
        c0_req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({frq_write_en, fin_write_en, frq_write_data} !== 4'b11_11) begin
            n_bad++; $display("FAIL wr_push: got %b want 1111", {frq_write_en, fin_write_en, frq_write_data});
        end
        n_cmp++;
        if (fin_write_data !== 32'h1) begin
            n_bad++; $display("FAIL wr_data: got %h want 00000001", fin_write_data);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({frq_write_en, fin_write_en} !== 2'b00) begin
            n_bad++; $display("FAIL wr_idle: got %b want 00", {frq_write_en, fin_write_en});
        end
    endtask

    // Two held reads alternate, fill the tag queue, then a write slips through and a return frees a tag.
    task automatic test_round_robin_tagfull();
        logic [7:0] exp0, exp1;
        exp0 = 8'b0001_0001;
        exp1 = 8'b0100_0100;
        test_reset();
        c0_req_valid = 1; c0_req_we = 0; c0_req_addr = 0;
        c1_req_valid = 1; c1_req_we = 0; c1_req_addr = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c0_req_ready, c1_req_ready} !== {exp0[i], exp1[i]}) begin
                n_bad++;
                $display("FAIL rr_ready[%0d]: got %b want %b", i, {c0_req_ready, c1_req_ready}, {exp0[i], exp1[i]});
            end
            if (i == 3) begin
                n_cmp++;
                if ({frq_write_en, frq_write_data} !== 3'b1_10) begin
                    n_bad++; $display("FAIL rr_req_c1: got %b want 110", {frq_write_en, frq_write_data});
                end
            end
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c0_req_ready, c1_req_ready} !== 2'b00) begin
                n_bad++; $display("FAIL tagfull_block[%0d]: got %b want 00", i, {c0_req_ready, c1_req_ready});
            end
            next_cycle();
        end
        c1_req_we = 1; c1_wdata = 32'h55;
        @(negedge clk);
        n_cmp++;
        if ({c0_req_ready, c1_req_ready} !== 2'b01) begin
            n_bad++; $display("FAIL tagfull_write: got %b want 01", {c0_req_ready, c1_req_ready});
        end
        next_cycle();
        c1_req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({fin_write_en, fin_write_data, frq_write_data} !== {1'b1, 32'h55, 2'b11}) begin
            n_bad++; $display("FAIL tagfull_wdata: got en=%b d=%h rq=%b want 1 00000055 11",
                              fin_write_en, fin_write_data, frq_write_data);
        end
        next_cycle();
        fout_empty = 0; fout_read_data = 32'hA;
        @(negedge clk);
        n_cmp++;
        if (c0_req_ready !== 1'b0) begin
            n_bad++; $display("FAIL tagfull_still: got %b want 0", c0_req_ready);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({fout_read_en, c0_rd_valid, c1_rd_valid, c0_rd_data} !== {3'b110, 32'hA}) begin
            n_bad++; $display("FAIL ret_c0: got re=%b v0=%b v1=%b d=%h want 1 1 0 0000000a",
                              fout_read_en, c0_rd_valid, c1_rd_valid, c0_rd_data);
        end
        n_cmp++;
        if (c0_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL tag_freed: got %b want 1", c0_req_ready);
        end
        next_cycle();
        c0_req_valid = 0; fout_empty = 1;
        @(negedge clk);
        n_cmp++;
        if ({fout_read_en, c0_rd_valid, frq_write_en, frq_write_data} !== 5'b0_0_1_00) begin
            n_bad++; $display("FAIL ret_done: got %b want 00100", {fout_read_en, c0_rd_valid, frq_write_en, frq_write_data});
        end
    endtask

    task automatic test_read_return();
        test_reset();
        c1_req_valid = 1; c1_req_we = 0; c1_req_addr = 1;
        @(negedge clk);
        n_cmp++;
        if (c1_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rd_grant: got %b want 1", c1_req_ready);
        end
        next_cycle();
        c1_req_valid = 0;
        next_cycle();
        fout_empty = 0; fout_read_data = 32'h1;
        next_cycle();
        fout_empty = 1;
        @(negedge clk);
        n_cmp++;
        if ({fout_read_en, c1_rd_valid, c0_rd_valid, c1_rd_data} !== {3'b110, 32'h1}) begin
            n_bad++; $display("FAIL rd_c1: got re=%b v1=%b v0=%b d=%h want 1 1 0 00000001",
                              fout_read_en, c1_rd_valid, c0_rd_valid, c1_rd_data);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({fout_read_en, c1_rd_valid, c0_rd_valid, error} !== 4'b0000) begin
            n_bad++; $display("FAIL rd_strobe_end: got %b want 0000", {fout_read_en, c1_rd_valid, c0_rd_valid, error});
        end
    endtask

    task automatic test_full_flags();
        test_reset();
        frq_full = 1;
        c0_req_valid = 1; c0_req_we = 1; c0_wdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c0_req_ready, frq_write_en, fin_write_en} !== 3'b000) begin
                n_bad++; $display("FAIL frq_full_block[%0d]: got %b want 000", i, {c0_req_ready, frq_write_en, fin_write_en});
            end
            next_cycle();
        end
        frq_full = 0;
        @(negedge clk);
        n_cmp++;
        if (c0_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL frq_full_release: got %b want 1", c0_req_ready);
        end
        next_cycle();
        fin_full = 1;
        c1_req_valid = 1; c1_req_we = 0; c1_req_addr = 0;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({c0_req_ready, c1_req_ready} !== 2'b01) begin
            n_bad++; $display("FAIL fin_full_read_ok: got %b want 01", {c0_req_ready, c1_req_ready});
        end
        next_cycle();
        c1_req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({frq_write_en, fin_write_en, frq_write_data} !== 4'b10_00) begin
            n_bad++; $display("FAIL fin_full_push: got %b want 1000", {frq_write_en, fin_write_en, frq_write_data});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (c0_req_ready !== 1'b0) begin
            n_bad++; $display("FAIL fin_full_block: got %b want 0", c0_req_ready);
        end
        c0_req_valid = 0; fin_full = 0;
    endtask

    task automatic test_error();
        test_reset();
        fout_empty = 0; fout_read_data = 32'h9;
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++; $display("FAIL err_early: got %b want 0", error);
        end
        next_cycle();
        fout_empty = 1;
        @(negedge clk);
        n_cmp++;
        if ({error, fout_read_en, c0_rd_valid, c1_rd_valid} !== 4'b1000) begin
            n_bad++; $display("FAIL err_set: got %b want 1000", {error, fout_read_en, c0_rd_valid, c1_rd_valid});
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: got %b want 1", error);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b want 0", error);
        end
        rst_n = 1'b1;
    endtask

`ifdef DRAM_ARB_PRIO_EN
    task automatic test_priority();
        test_reset();
        c0_req_valid = 1; c0_req_we = 1; c0_wdata = 32'h3;
        c1_req_valid = 1; c1_req_we = 1; c1_wdata = 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c0_req_ready, c1_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b00)) begin
                n_bad++; $display("FAIL prio[%0d]: got %b want %b", i, {c0_req_ready, c1_req_ready},
                                  (i % 2 == 0) ? 2'b10 : 2'b00);
            end
            next_cycle();
        end
        c0_req_valid = 0; c1_req_valid = 0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_write();
        test_round_robin_tagfull();
        test_read_return();
        test_full_flags();
        test_error();
`ifdef DRAM_ARB_PRIO_EN
        test_priority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
